// File: rtl/fft_spectrum_buf_ctrl.sv
// FFT output capture into a ping-pong magnitude buffer, swapped only on LCD screen start.
// Optional macro SPECTRUM_PEAK_HOLD_EN adds per-frame peak bin/magnitude tracking.
module fft_spectrum_buf_ctrl #(
  parameter int N_POINTS = 128,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int MAG_W    = 17
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              fft_src_valid,
  input  logic              fft_src_sop,
  input  logic              fft_src_eop,
  input  logic [1:0]        fft_src_error,
  input  logic [DATA_W-1:0] fft_src_real,
  input  logic [DATA_W-1:0] fft_src_imag,
  output logic              fft_src_ready,
  input  logic              lcd_frame_req,
  input  logic [ADDR_W-1:0] lcd_rd_addr,
  output logic [MAG_W-1:0]  lcd_rd_data,
  output logic              frame_ready,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [MAG_W-1:0]  peak_mag
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_wr_idx;
  logic               r_rd_bank;
  logic               r_wr_bank;
  logic               r_pending;
  logic               r_ready;
  logic               r_frame_ready;
  logic [7:0]         r_frame_cnt;
  logic [7:0]         r_err_cnt;
  logic               r_wr_en;
  logic               r_wr_last;
  logic [ADDR_W:0]    r_wr_addr;
  logic [MAG_W-1:0]   r_wr_mag;
  logic [MAG_W-1:0]   r_rd_data;
  logic [MAG_W-1:0]   r_mem [0:2*N_POINTS-1];

  logic [MAG_W-1:0]   w_re_ext;
  logic [MAG_W-1:0]   w_im_ext;
  logic [MAG_W-1:0]   w_re_abs;
  logic [MAG_W-1:0]   w_im_abs;
  logic [MAG_W-1:0]   w_mag;
  logic               w_swap;
  logic               w_wr_bank;
  logic               w_last_idx;

  // One extra bit of headroom makes |re|+|im| exact, including -2^(DATA_W-1) on both parts.
  assign w_re_ext = MAG_W'($signed(fft_src_real));
  assign w_im_ext = MAG_W'($signed(fft_src_imag));
  assign w_re_abs = w_re_ext[MAG_W-1] ? ((~w_re_ext) + MAG_W'(1)) : w_re_ext;
  assign w_im_abs = w_im_ext[MAG_W-1] ? ((~w_im_ext) + MAG_W'(1)) : w_im_ext;
  assign w_mag    = w_re_abs + w_im_abs;

  // A swap waits until the final bin of the pending frame has actually landed in RAM.
  assign w_swap     = lcd_frame_req & r_pending & ~(r_wr_en & r_wr_last);
  assign w_wr_bank  = w_swap ? r_rd_bank : r_wr_bank;
  assign w_last_idx = (r_wr_idx == ADDR_W'(N_POINTS - 1));

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_idx      <= '0;
      r_rd_bank     <= 1'b0;
      r_wr_bank     <= 1'b1;
      r_pending     <= 1'b0;
      r_ready       <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
      r_wr_en       <= 1'b0;
      r_wr_last     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_mag      <= '0;
    end else begin
      r_ready       <= 1'b1;
      r_wr_en       <= 1'b0;
      r_wr_last     <= 1'b0;
      r_frame_ready <= 1'b0;
      if (w_swap) begin
        r_rd_bank     <= r_wr_bank;
        r_wr_bank     <= r_rd_bank;
        r_pending     <= 1'b0;
        r_frame_ready <= 1'b1;
        r_frame_cnt   <= r_frame_cnt + 8'd1;
      end
      if (fft_src_valid) begin
        case (r_state)
          S_IDLE: begin
            if (fft_src_sop && (fft_src_error == 2'b00)) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= {w_wr_bank, {ADDR_W{1'b0}}};
              r_wr_mag  <= w_mag;
              r_wr_idx  <= ADDR_W'(1);
              r_pending <= 1'b0;
              r_state   <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (fft_src_error != 2'b00) begin
              r_err_cnt <= sat_inc(r_err_cnt);
              r_wr_idx  <= '0;
              r_state   <= S_IDLE;
            end else if (fft_src_sop) begin
              r_err_cnt <= sat_inc(r_err_cnt);
              r_wr_en   <= 1'b1;
              r_wr_addr <= {w_wr_bank, {ADDR_W{1'b0}}};
              r_wr_mag  <= w_mag;
              r_wr_idx  <= ADDR_W'(1);
            end else if (fft_src_eop) begin
              if (w_last_idx) begin
                r_wr_en   <= 1'b1;
                r_wr_last <= 1'b1;
                r_wr_addr <= {w_wr_bank, r_wr_idx};
                r_wr_mag  <= w_mag;
                r_pending <= 1'b1;
              end else begin
                r_err_cnt <= sat_inc(r_err_cnt);
              end
              r_wr_idx <= '0;
              r_state  <= S_IDLE;
            end else if (w_last_idx) begin
              r_err_cnt <= sat_inc(r_err_cnt);
              r_wr_idx  <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= {w_wr_bank, r_wr_idx};
              r_wr_mag  <= w_mag;
              r_wr_idx  <= r_wr_idx + ADDR_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (r_wr_en) r_mem[r_wr_addr] <= r_wr_mag;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[{r_rd_bank, lcd_rd_addr}];
  end

  assign fft_src_ready = r_ready;
  assign lcd_rd_data   = r_rd_data;
  assign frame_ready   = r_frame_ready;
  assign frame_cnt     = r_frame_cnt;
  assign err_cnt       = r_err_cnt;

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [MAG_W-1:0]  r_run_mag;
  logic [ADDR_W-1:0] r_run_bin;
  logic [MAG_W-1:0]  r_cand_mag;
  logic [ADDR_W-1:0] r_cand_bin;
  logic [MAG_W-1:0]  r_peak_mag;
  logic [ADDR_W-1:0] r_peak_bin;
  logic              w_take;
  logic [MAG_W-1:0]  w_max_mag;
  logic [ADDR_W-1:0] w_max_bin;

  // Bin 0 is only ever written at frame start, so it restarts the running max; strict > keeps the lower bin on ties.
  assign w_take    = (r_wr_addr[ADDR_W-1:0] == '0) || (r_wr_mag > r_run_mag);
  assign w_max_mag = w_take ? r_wr_mag : r_run_mag;
  assign w_max_bin = w_take ? r_wr_addr[ADDR_W-1:0] : r_run_bin;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_run_mag  <= '0;
      r_run_bin  <= '0;
      r_cand_mag <= '0;
      r_cand_bin <= '0;
      r_peak_mag <= '0;
      r_peak_bin <= '0;
    end else begin
      if (r_wr_en) begin
        r_run_mag <= w_max_mag;
        r_run_bin <= w_max_bin;
        if (r_wr_last) begin
          r_cand_mag <= w_max_mag;
          r_cand_bin <= w_max_bin;
        end
      end
      if (w_swap) begin
        r_peak_mag <= r_cand_mag;
        r_peak_bin <= r_cand_bin;
      end
    end
  end

  assign peak_mag = r_peak_mag;
  assign peak_bin = r_peak_bin;
`else
  assign peak_mag = '0;
  assign peak_bin = '0;
`endif

endmodule

// File: tb/tb_fft_spectrum_buf_ctrl.sv
// Bench for fft_spectrum_buf_ctrl: directed scenarios plus randomized frames against a frame-level model.
module tb_fft_spectrum_buf_ctrl;
  localparam int N  = 128;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int MW = 17;

  localparam int K_GOOD  = 0;
  localparam int K_EARLY = 1;
  localparam int K_NOEOP = 2;
  localparam int K_ERR   = 3;
  localparam int K_ABORT = 4;

  logic          clk_50m = 1'b0;
  logic          rst_n = 1'b0;
  logic          fft_src_valid = 1'b0;
  logic          fft_src_sop = 1'b0;
  logic          fft_src_eop = 1'b0;
  logic [1:0]    fft_src_error = 2'b00;
  logic [DW-1:0] fft_src_real = '0;
  logic [DW-1:0] fft_src_imag = '0;
  logic          fft_src_ready;
  logic          lcd_frame_req = 1'b0;
  logic [AW-1:0] lcd_rd_addr = '0;
  logic [MW-1:0] lcd_rd_data;
  logic          frame_ready;
  logic [7:0]    frame_cnt;
  logic [7:0]    err_cnt;
  logic [AW-1:0] peak_bin;
  logic [MW-1:0] peak_mag;

  fft_spectrum_buf_ctrl #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW), .MAG_W(MW)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n),
    .fft_src_valid(fft_src_valid), .fft_src_sop(fft_src_sop), .fft_src_eop(fft_src_eop),
    .fft_src_error(fft_src_error), .fft_src_real(fft_src_real), .fft_src_imag(fft_src_imag),
    .fft_src_ready(fft_src_ready), .lcd_frame_req(lcd_frame_req),
    .lcd_rd_addr(lcd_rd_addr), .lcd_rd_data(lcd_rd_data), .frame_ready(frame_ready),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  // clock / reset
  always #10 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_seen = 0;
  always @(negedge clk_50m) if (frame_ready === 1'b1) pulse_seen++;

  // reference model state (frame level)
  int        disp_mag [N];
  int        pend_mag [N];
  bit        disp_valid = 1'b0;
  bit        m_pending = 1'b0;
  bit        m_open = 1'b0;
  int        m_frame_cnt = 0;
  int        m_err_cnt = 0;
  int        m_pulses = 0;
  int        m_cand_bin = 0, m_cand_mag = 0;
  int        m_peak_bin = 0, m_peak_mag = 0;
  logic [DW-1:0] gen_re [N];
  logic [DW-1:0] gen_im [N];
  logic [MW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input logic [DW-1:0] re, input logic [DW-1:0] im);
    int a = int'($signed(re));
    int b = int'($signed(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return a + b;
  endfunction

  function automatic logic [DW-1:0] rand_sample();
    case ($urandom_range(0, 9))
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return DW'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      gen_re[k] = rand_sample();
      gen_im[k] = rand_sample();
    end
  endtask

  task automatic fill_const_mag(input int m);
    for (int k = 0; k < N; k++) begin
      int r = $urandom_range(0, m);
      int i = m - r;
      gen_re[k] = DW'($urandom_range(0, 1) ? -r : r);
      gen_im[k] = DW'($urandom_range(0, 1) ? -i : i);
    end
  endtask

  // driver tasks
  task automatic idle_cycle();
    @(posedge clk_50m); #1;
    fft_src_valid = 1'b0; fft_src_sop = 1'b0; fft_src_eop = 1'b0;
    fft_src_error = 2'b00; lcd_frame_req = 1'b0;
  endtask

  task automatic drive_sample(input bit sop, input bit eop, input logic [1:0] err,
                              input logic [DW-1:0] re, input logic [DW-1:0] im, input bit req);
    while ($urandom_range(0, 4) == 0) idle_cycle();
    @(posedge clk_50m); #1;
    fft_src_valid = 1'b1; fft_src_sop = sop; fft_src_eop = eop;
    fft_src_error = err; fft_src_real = re; fft_src_imag = im; lcd_frame_req = req;
  endtask

  task automatic model_swap();
    if (m_pending) begin
      for (int k = 0; k < N; k++) disp_mag[k] = pend_mag[k];
      disp_valid  = 1'b1;
      m_pending   = 1'b0;
      m_frame_cnt = (m_frame_cnt + 1) % 256;
      m_pulses++;
      m_peak_bin  = m_cand_bin;
      m_peak_mag  = m_cand_mag;
    end
  endtask

  task automatic model_err();
    if (m_err_cnt < 255) m_err_cnt++;
  endtask

  task automatic drive_frame(input int kind, input int param, input bit req_at_sop);
    int last;
    if (req_at_sop) model_swap();
    if (m_open) model_err();
    m_open = 1'b0;
    m_pending = 1'b0;
    last = (kind == K_GOOD || kind == K_NOEOP) ? N - 1 : (kind == K_ABORT ? param - 1 : param);
    for (int k = 0; k <= last; k++) begin
      drive_sample(k == 0,
                   (kind == K_GOOD && k == N - 1) || (kind == K_EARLY && k == param),
                   (kind == K_ERR && k == param) ? 2'($urandom_range(1, 3)) : 2'b00,
                   gen_re[k], gen_im[k], req_at_sop && (k == 0));
    end
    idle_cycle();
    if (kind == K_GOOD) begin
      m_cand_mag = -1;
      for (int k = 0; k < N; k++) begin
        pend_mag[k] = mag_of(gen_re[k], gen_im[k]);
        if (pend_mag[k] > m_cand_mag) begin
          m_cand_mag = pend_mag[k];
          m_cand_bin = k;
        end
      end
      m_pending = 1'b1;
    end else if (kind == K_ABORT) begin
      m_open = 1'b1;
    end else begin
      model_err();
    end
  endtask

  task automatic do_req();
    @(posedge clk_50m); #1;
    lcd_frame_req = 1'b1;
    model_swap();
    idle_cycle();
    idle_cycle();
  endtask

  task automatic read_one(input int a, output logic [MW-1:0] d);
    @(posedge clk_50m); #1;
    lcd_rd_addr = AW'(a);
    @(posedge clk_50m); #1;
    d = lcd_rd_data;
  endtask

  // scoreboard: back-to-back reads, one result per cycle
  task automatic check_display(input string tag);
    if (!disp_valid) return;
    for (int a = 0; a < N; a++) begin
      @(posedge clk_50m); #1;
      if (a > 0) check($sformatf("%s_rd%0d", tag, a - 1), 32'(lcd_rd_data), 32'(exp_q.pop_front()));
      lcd_rd_addr = AW'(a);
      exp_q.push_back(MW'(disp_mag[a]));
    end
    @(posedge clk_50m); #1;
    check($sformatf("%s_rd%0d", tag, N - 1), 32'(lcd_rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pulses"}, 32'(pulse_seen), 32'(m_pulses));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frame_cnt));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err_cnt));
`ifdef SPECTRUM_PEAK_HOLD_EN
    check({tag, "_peak_bin"}, 32'(peak_bin), 32'(m_peak_bin));
    check({tag, "_peak_mag"}, 32'(peak_mag), 32'(m_peak_mag));
`else
    check({tag, "_peak_bin"}, 32'(peak_bin), 32'd0);
    check({tag, "_peak_mag"}, 32'(peak_mag), 32'd0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(fft_src_ready), 32'd0);
    check({tag, "_rd_data"}, 32'(lcd_rd_data), 32'd0);
    check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_peak_bin"}, 32'(peak_bin), 32'd0);
    check({tag, "_peak_mag"}, 32'(peak_mag), 32'd0);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] d;
    int kind, param;

    // reset state
    repeat (3) @(posedge clk_50m);
    #1;
    check_reset_values("reset");
    @(negedge clk_50m);
    rst_n = 1'b1;
    @(posedge clk_50m); #1;
    check("ready_after_reset", 32'(fft_src_ready), 32'd1);

    // 1: ramp frame re=k, im=-k
    for (int k = 0; k < N; k++) begin
      gen_re[k] = DW'(k);
      gen_im[k] = DW'(-k);
    end
    drive_frame(K_GOOD, 0, 1'b0);
    check("t1_no_pulse_before_req", 32'(pulse_seen), 32'd0);
    do_req();
    check_status("t1");
    check("t1_frame_cnt_is_1", 32'(frame_cnt), 32'd1);
    read_one(5, d);
    check("t1_addr5", 32'(d), 32'd10);
    check_display("t1");

    // 2: worst-case magnitude
    fill_random();
    gen_re[3] = 16'h8000;
    gen_im[3] = 16'h8000;
    drive_frame(K_GOOD, 0, 1'b0);
    do_req();
    check_status("t2");
    read_one(3, d);
    check("t2_addr3_max", 32'(d), 32'd65536);
    check_display("t2");

    // 3: early eop drops the frame; request does nothing
    fill_random();
    drive_frame(K_EARLY, 100, 1'b0);
    check("t3_err_cnt_is_1", 32'(err_cnt), 32'd1);
    do_req();
    check_status("t3");
    check_display("t3");

    // 4: newest complete frame wins
    fill_const_mag(4);
    drive_frame(K_GOOD, 0, 1'b0);
    fill_const_mag(9);
    drive_frame(K_GOOD, 0, 1'b0);
    do_req();
    check_status("t4");
    read_one(77, d);
    check("t4_addr77", 32'(d), 32'd9);
    check_display("t4");

    // 5: request coincident with the next frame's sop
    fill_random();
    drive_frame(K_GOOD, 0, 1'b0);
    fill_random();
    drive_frame(K_GOOD, 0, 1'b1);
    check_status("t5_swap_at_sop");
    check_display("t5_old");
    do_req();
    check_status("t5_next");
    check_display("t5_new");

    // 6: peak tracking with a tie
    for (int k = 0; k < N; k++) begin
      gen_re[k] = DW'($signed($urandom_range(0, 40)) - 20);
      gen_im[k] = DW'($signed($urandom_range(0, 40)) - 20);
    end
    gen_re[20] = DW'(25);  gen_im[20] = DW'(-25);
    gen_re[90] = DW'(-50); gen_im[90] = DW'(0);
    drive_frame(K_GOOD, 0, 1'b0);
    do_req();
    check_status("t6");
`ifdef SPECTRUM_PEAK_HOLD_EN
    check("t6_peak_bin", 32'(peak_bin), 32'd20);
    check("t6_peak_mag", 32'(peak_mag), 32'd50);
`else
    check("t6_peak_bin", 32'(peak_bin), 32'd0);
    check("t6_peak_mag", 32'(peak_mag), 32'd0);
`endif

    // 7: randomized frame mix
    repeat (14) begin
      kind = $urandom_range(0, 4);
      case (kind)
        K_ERR:   param = $urandom_range(1, N - 1);
        K_EARLY: param = $urandom_range(1, N - 2);
        K_ABORT: param = $urandom_range(1, N - 2);
        default: param = 0;
      endcase
      fill_random();
      drive_frame(kind, param, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_req();
      check_status($sformatf("rnd_k%0d", kind));
    end
    fill_random();
    drive_frame(K_GOOD, 0, 1'b0);
    do_req();
    check_status("rnd_close");
    check_display("rnd_close");

    // 8: error counter saturation
    repeat (260) begin
      gen_re[0] = rand_sample(); gen_im[0] = rand_sample();
      drive_frame(K_ERR, 1, 1'b0);
    end
    check("t8_err_sat", 32'(err_cnt), 32'd255);
    check_status("t8");
    check_display("t8");

    // 9: reset in the middle of a frame
    fill_random();
    for (int k = 0; k < 50; k++) drive_sample(k == 0, 1'b0, 2'b00, gen_re[k], gen_im[k], 1'b0);
    @(posedge clk_50m); #1;
    rst_n = 1'b0;
    fft_src_valid = 1'b0; fft_src_sop = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
    m_pending = 1'b0; m_open = 1'b0; m_frame_cnt = 0; m_err_cnt = 0;
    m_peak_bin = 0; m_peak_mag = 0; disp_valid = 1'b0;
    check_status("t9_after_reset");
    fill_random();
    drive_frame(K_GOOD, 0, 1'b0);
    do_req();
    check_status("t9");
    check("t9_frame_cnt_is_1", 32'(frame_cnt), 32'd1);
    check_display("t9");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
